// File: rtl/d5m_pattern_gen_if.sv
// Control and video bus of the D5M-style pattern generator.
// The master modport is the generator side; the slave modport is the controller/sink side.
interface d5m_pattern_gen_if;
  logic        i_start;
  logic        i_stop;
  logic [1:0]  i_pattern;
  logic        o_FVAL;
  logic        o_LVAL;
  logic [11:0] o_D;
  logic [15:0] o_frame_cnt;
  logic        o_busy;

  modport master (
    input  i_start, i_stop, i_pattern,
    output o_FVAL, o_LVAL, o_D, o_frame_cnt, o_busy
  );

  modport slave (
    output i_start, i_stop, i_pattern,
    input  o_FVAL, o_LVAL, o_D, o_frame_cnt, o_busy
  );
endinterface

// File: rtl/d5m_pattern_gen.sv
// Terasic D5M-style raw Bayer test-pattern source: FVAL/LVAL framing plus bars/gradient/checker.
// Define D5M_GEN_PRBS_EN to make pattern 3 a per-frame-repeatable 12-bit LFSR (otherwise it is zero).
module d5m_pattern_gen #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int H_BLANK = 160,
  parameter int V_BLANK = 45,
  parameter int FV_PRE  = 4,
  parameter int FV_POST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  d5m_pattern_gen_if.master     bus
);

  localparam logic [15:0] H_LAST    = 16'(H_ACT - 1);
  localparam logic [15:0] Y_LAST    = 16'(V_ACT - 1);
  localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);
  localparam logic [15:0] PRE_LAST  = 16'(FV_PRE - 1);
  localparam logic [15:0] POST_LAST = 16'(FV_POST - 1);
  localparam int          BAR_W     = (H_ACT >= 8) ? (H_ACT / 8) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VBLANK,
    ST_FV_PRE,
    ST_LINE,
    ST_HBLANK,
    ST_FV_POST
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] y_q, y_d;
  logic [1:0]  pattern_q, pattern_d;
  logic        stop_pend_q, stop_pend_d;
  logic        fval_q, fval_d;
  logic        lval_q, lval_d;
  logic [11:0] data_q, data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        busy_q, busy_d;
  logic [11:0] prbs_pix;

  logic [15:0] bar_idx;
  logic [2:0]  bar_sel;
  logic [2:0]  bar_rgb;
  logic        comp_on;

`ifdef D5M_GEN_PRBS_EN
  localparam logic [11:0] PRBS_SEED = 12'hACE;
  logic [11:0] lfsr_q, lfsr_d;

  assign prbs_pix = lfsr_q;

  // Reseeded on every frame start and stepped once per emitted pixel, so frames repeat exactly.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_d == ST_FV_PRE && state_q != ST_FV_PRE) begin
      lfsr_d = PRBS_SEED;
    end else if (lval_d) begin
      lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 12'h000;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign prbs_pix = 12'h000;
`endif

  // Sequencing: cnt_q counts cycles inside the current state and doubles as x during LINE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    y_d         = y_q;
    pattern_d   = pattern_q;
    stop_pend_d = stop_pend_q | (bus.i_stop && (state_q != ST_IDLE));
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d       = 16'd0;
        stop_pend_d = 1'b0;
        if (bus.i_start) begin
          state_d   = ST_FV_PRE;
          pattern_d = bus.i_pattern;
        end
      end
      ST_FV_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = ST_LINE;
          cnt_d   = 16'd0;
          y_d     = 16'd0;
        end
      end
      ST_LINE: begin
        if (cnt_q == H_LAST) begin
          cnt_d   = 16'd0;
          state_d = (y_q == Y_LAST) ? ST_FV_POST : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = ST_LINE;
          cnt_d   = 16'd0;
          y_d     = y_q + 16'd1;
        end
      end
      ST_FV_POST: begin
        if (cnt_q == POST_LAST) begin
          cnt_d       = 16'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (stop_pend_q || bus.i_stop) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_VBLANK;
          end
        end
      end
      ST_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          state_d   = ST_FV_PRE;
          cnt_d     = 16'd0;
          pattern_d = bus.i_pattern;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output decode works on the next-state values so the registered outputs line up with state_q.
  always_comb begin
    fval_d  = (state_d == ST_FV_PRE) || (state_d == ST_LINE) ||
              (state_d == ST_HBLANK) || (state_d == ST_FV_POST);
    lval_d  = (state_d == ST_LINE);
    busy_d  = (state_d != ST_IDLE);

    bar_idx = cnt_d / 16'(BAR_W);
    bar_sel = (bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0];
    unique case (bar_sel)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase

    // Bayer site: R on even row/odd column, B on odd row/even column, G elsewhere.
    if (!y_d[0] && cnt_d[0]) begin
      comp_on = bar_rgb[2];
    end else if (y_d[0] && !cnt_d[0]) begin
      comp_on = bar_rgb[0];
    end else begin
      comp_on = bar_rgb[1];
    end

    data_d = 12'h000;
    if (lval_d) begin
      unique case (pattern_q)
        2'd0:    data_d = comp_on ? 12'hFFF : 12'h000;
        2'd1:    data_d = {cnt_d[9:0], 2'b00};
        2'd2:    data_d = (cnt_d[3] ^ y_d[3]) ? 12'hFFF : 12'h000;
        default: data_d = prbs_pix;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      y_q         <= 16'd0;
      pattern_q   <= 2'd0;
      stop_pend_q <= 1'b0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      data_q      <= 12'h000;
      frame_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      pattern_q   <= pattern_d;
      stop_pend_q <= stop_pend_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_FVAL      = fval_q;
  assign bus.o_LVAL      = lval_q;
  assign bus.o_D         = data_q;
  assign bus.o_frame_cnt = frame_cnt_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: doc/d5m_pattern_gen.md
D5M_PATTERN_GEN -- requirements
Module: d5m_pattern_gen

Interface
REQ-001 Parameter H_ACT, 640, active pixels per line (LVAL-high cycles).
REQ-002 Parameter V_ACT, 480, active lines per frame.
REQ-003 Parameter H_BLANK, 160, LVAL-low cycles between lines.
REQ-004 Parameter V_BLANK, 45, FVAL-low cycles between frames.
REQ-005 Parameter FV_PRE, 4, FVAL-high cycles before the first LVAL; FV_POST, 4, FVAL-high cycles after the last LVAL.
REQ-006 Port i_clk, input, 1, pixel clock; one pixel per rising edge.
REQ-007 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port i_start, input, 1, single-cycle pulse that starts continuous frame generation.
REQ-009 Port i_stop, input, 1, single-cycle pulse that requests stop at the end of the current frame.
REQ-010 Port i_pattern, input, 2, pattern select.
REQ-011 Port o_FVAL, output, 1, frame valid.
REQ-012 Port o_LVAL, output, 1, line valid.
REQ-013 Port o_D, output, 12, Bayer raw pixel data.
REQ-014 Port o_frame_cnt, output, 16, count of completed frames.
REQ-015 Port o_busy, output, 1, high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, VBLANK, FV_PRE, LINE, HBLANK and FV_POST.
- IDLE -> FV_PRE on i_start.
- FV_PRE (FV_PRE cycles) -> LINE.
- LINE (H_ACT cycles) -> HBLANK, or -> FV_POST after line V_ACT-1.
- HBLANK (H_BLANK cycles) -> LINE.
- FV_POST (FV_POST cycles) -> IDLE if a stop is pending, else -> VBLANK.
- VBLANK (V_BLANK cycles) -> FV_PRE.
REQ-017 All outputs SHALL be registered; o_FVAL is high in FV_PRE, LINE, HBLANK and FV_POST; o_LVAL is high only in LINE.
REQ-018 o_D SHALL be 12'h000 whenever o_LVAL is low.
REQ-019 x (0..H_ACT-1) and y (0..V_ACT-1) SHALL reset to 0 at each line and frame start respectively.
- Bayer site: even y / even x = G1; even y / odd x = R; odd y / even x = B; odd y / odd x = G2.
REQ-020 i_pattern SHALL be latched on entry to FV_PRE; changes mid-frame take effect on the next frame.
REQ-021 Pattern 0 (colour bars) SHALL use 8 bars of width H_ACT/8, bar = x/(H_ACT/8).
- Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- o_D = 12'hFFF where the bar contains the site's colour component, else 12'h000.
REQ-022 Pattern 1 (gradient) SHALL output o_D = {x[9:0],2'b00}.
REQ-023 Pattern 2 (checker) SHALL output o_D = 12'hFFF when x[3]^y[3] is 1, else 12'h000.
REQ-024 Pattern 3 SHALL be as defined under Configuration.
REQ-025 o_frame_cnt SHALL increment by 1 on the cycle o_FVAL falls and wrap from 16'hFFFF to 0.
REQ-026 Boundary conditions:
- i_start while busy SHALL be ignored.
- i_stop while IDLE SHALL be ignored.
- i_stop sets a sticky pending flag, cleared on entry to IDLE.
- A frame in progress is never truncated.
- i_start and i_stop in the same IDLE cycle: start wins and the stop is discarded.

Reset
REQ-027 While i_rst_n is low, the block SHALL be in IDLE with o_FVAL=0, o_LVAL=0, o_D=0, o_frame_cnt=0, o_busy=0, stop-pending=0, latched pattern=0, and all counters 0.
- Reset asserted mid-frame SHALL drop FVAL/LVAL immediately (asynchronously) without incrementing o_frame_cnt.

Configuration
REQ-028 With macro D5M_GEN_PRBS_EN defined, pattern 3 SHALL output a 12-bit Fibonacci LFSR (x^12+x^6+x^4+x+1).
- The LFSR is seeded to 12'hACE on each FV_PRE entry and advances only on LVAL-high cycles, so every frame is identical.
REQ-029 Without D5M_GEN_PRBS_EN, pattern 3 SHALL output 12'h000 and no LFSR logic SHALL be present.

Verification (H_ACT=8, V_ACT=4, H_BLANK=3, V_BLANK=5, FV_PRE=2, FV_POST=2)
REQ-030 Timing: i_start -> per frame, FVAL high 2+4*8+3*3+2=45 cycles, 4 LVAL pulses of 8 cycles separated by 3 low cycles, then FVAL low for 5 cycles.
REQ-031 Checker (i_pattern=2): row y=0 -> o_D=000 for x=0..7 (x[3]=0); with H_ACT=16, row 0 -> x=8..15 give FFF.
REQ-032 Colour bars (i_pattern=0): y=0, x=0 (white, G1) -> FFF; y=0, x=7 (black, R) -> 000; y=0, x=5 (red, R) -> FFF.
REQ-033 Stop: i_stop asserted during line 1 -> frame finishes all 4 lines and FV_POST, o_frame_cnt increments 0->1, then IDLE with o_busy=0; a second i_stop while IDLE -> no effect.
REQ-034 Reset mid-operation: i_rst_n low during LINE -> o_FVAL=o_LVAL=0 immediately and o_frame_cnt=0; i_start after release -> a full frame starting from y=0.
REQ-035 With D5M_GEN_PRBS_EN and i_pattern=3: the first pixel of two consecutive frames -> 12'hACE both times, and the 32-pixel sequences of the two frames are identical.
